// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-loader state encoding, used by the
// loader, program_counter and instruction_memory.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int INST_W = 32;
  localparam int BYTES_PER_WORD = INST_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/instruction_loader_word_packer.sv
// Assembles a little-endian byte stream into instruction words and tracks the
// byte position within the current word.
module word_packer #(
  parameter int INST_W = cpu_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic [7:0]        in_data,
  output logic              last_byte,
  output logic [INST_W-1:0] word_next
);

  localparam int CNT_W = $clog2(INST_W / 8);

  // Only the upper bytes are kept: the lowest byte of the held value is
  // always shifted out by the next transfer, so it never needs storage.
  logic [INST_W-9:0] word_q;
  logic [CNT_W-1:0]  byte_cnt;

  assign word_next = {in_data, word_q};
  assign last_byte = (byte_cnt == CNT_W'((INST_W / 8) - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word_q   <= word_next[INST_W-1:8];
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Boot-time loader: streams bytes into instruction memory word by word while
// holding the CPU in reset, then pulses done and releases the CPU.
module instruction_loader #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     len,
  input  logic                  abort,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_W-1:0]     waddr,
  output logic [INST_W-1:0]     wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output cpu_pkg::loader_state_e state
);

  import cpu_pkg::*;

  // Byte handshake: a byte moves on a rising edge where in_valid and
  // in_ready are both high; in_ready is only offered in LOAD without abort,
  // and in_valid may drop for any number of cycles without losing position.

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] word_cnt;
  logic              accept;
  logic              xfer;
  logic              cancel;
  logic              last_word;
  logic              last_byte;
  logic [INST_W-1:0] word_next;

  assign accept    = (state_q == ST_IDLE) && start;
  assign cancel    = abort && ((state_q == ST_LOAD) || (state_q == ST_WRITE));
  assign xfer      = in_ready && in_valid;
  // len of zero wraps to 255 here, giving a full 256-word load.
  assign last_word = (word_cnt == ADDR_W'(len_q - 1'b1));

  word_packer #(
    .INST_W(INST_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept || cancel),
    .shift    (xfer),
    .in_data  (in_data),
    .last_byte(last_byte),
    .word_next(word_next)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    we       = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = !abort;
        if (abort)                  state_d = ST_IDLE;
        else if (in_valid && last_byte) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        we = !abort;
        if (abort)          state_d = ST_IDLE;
        else if (last_word) state_d = ST_DONE;
        else                state_d = ST_LOAD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign cpu_hold = busy;
  assign state    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        len_q    <= len;
        word_cnt <= '0;
      end
      // Address and data are captured on entry to WRITE and then held.
      if (xfer && last_byte) begin
        waddr <= word_cnt;
        wdata <= word_next;
      end
      if ((state_q == ST_WRITE) && !abort && !last_word) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: scenario tasks with inline checks and
// a negedge write scoreboard fed from an expected queue.
module tb_instruction_loader;

  import cpu_pkg::*;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] len;
  logic          abort;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] wdata;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  loader_state_e state;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  logic prev_we = 1'b0;
  logic [AW-1:0] last_waddr = '0;
  logic [AW+IW-1:0] exp_q[$];

  instruction_loader #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .state(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (we) begin
        logic [AW+IW-1:0] e;
        wr_cnt++;
        last_waddr = waddr;
        n_vec++;
        if (prev_we) begin
          n_err++;
          $display("FAIL we_width: we high on consecutive cycles, waddr=%0d", waddr);
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got waddr=%0d wdata=%h, required no write", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            n_err++;
            $display("FAIL write_data: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                     waddr, wdata, e[AW+IW-1:IW], e[IW-1:0]);
          end
        end
      end
      prev_we = we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // ---------------- drivers (called at posedge+1) ----------------
  task automatic clear_sb();
    exp_q.delete();
    done_cnt = 0;
    wr_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] l);
    start = 1'b1;
    len = l;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_data = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 20 cycles, required 1");
    end
    step();
    in_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    ok = !busy;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_vec++;
    if ({we, in_ready, busy, cpu_hold, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got we/rdy/busy/hold/done=%b, required 00000",
               {we, in_ready, busy, cpu_hold, done});
    end
    n_vec++;
    if (waddr !== '0 || wdata !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got waddr=%h wdata=%h, required 0/0", waddr, wdata);
    end
    n_vec++;
    if (state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d, required %0d", state, ST_IDLE);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_sb();
    exp_q.push_back({8'd0, 32'h0000_0004});
    do_start(8'd1);
    n_vec++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL single_start: got busy=%b hold=%b, required 1/1", busy, cpu_hold);
    end
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    n_vec++;
    if (we !== 1'b1 || waddr !== 8'd0 || wdata !== 32'h0000_0004) begin
      n_err++;
      $display("FAIL single_write: got we=%b waddr=%0d wdata=%h, required 1/0/00000004",
               we, waddr, wdata);
    end
    step();
    n_vec++;
    if (done !== 1'b1 || we !== 1'b0 || cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got done=%b we=%b hold=%b, required 1/0/1", done, we, cpu_hold);
    end
    step();
    n_vec++;
    if (done !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: got done=%b hold=%b busy=%b, required 0/0/0",
               done, cpu_hold, busy);
    end
    wait_idle(10, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0 || done_cnt != 1 || waddr !== 8'd0 || wdata !== 32'h4) begin
      n_err++;
      $display("FAIL single_end: got idle=%0d left=%0d dones=%0d waddr=%0d wdata=%h, required 1/0/1/0/4",
               ok, exp_q.size(), done_cnt, waddr, wdata);
    end
  endtask

  task automatic test_gaps();
    bit ok;
    logic [7:0] b[16];
    clear_sb();
    for (int i = 0; i < 16; i++) b[i] = 8'(8'h10 + i * 3);
    for (int w = 0; w < 4; w++)
      exp_q.push_back({8'(w), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    do_start(8'd4);
    for (int i = 0; i < 16; i++) send_byte(b[i], 1);
    wait_idle(40, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0 || wr_cnt != 4 || done_cnt != 1) begin
      n_err++;
      $display("FAIL gaps_end: got idle=%0d left=%0d writes=%0d dones=%0d, required 1/0/4/1",
               ok, exp_q.size(), wr_cnt, done_cnt);
    end
  endtask

  task automatic test_abort();
    bit ok;
    clear_sb();
    exp_q.push_back({8'd0, 32'hA3A2_A1A0});
    do_start(8'd3);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || state !== ST_IDLE) begin
      n_err++;
      $display("FAIL abort_idle: got busy=%b rdy=%b state=%0d, required 0/0/%0d",
               busy, in_ready, state, ST_IDLE);
    end
    repeat (5) step();
    n_vec++;
    if (wr_cnt != 1 || done_cnt != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_quiet: got writes=%0d dones=%0d left=%0d, required 1/0/0",
               wr_cnt, done_cnt, exp_q.size());
    end
    clear_sb();
    exp_q.push_back({8'd0, 32'hDDCC_BBAA});
    do_start(8'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    send_byte(8'hCC, 0);
    send_byte(8'hDD, 0);
    wait_idle(10, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0 || wr_cnt != 1 || done_cnt != 1) begin
      n_err++;
      $display("FAIL abort_reload: got idle=%0d left=%0d writes=%0d dones=%0d, required 1/0/1/1",
               ok, exp_q.size(), wr_cnt, done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [7:0] b[8];
    clear_sb();
    for (int i = 0; i < 8; i++) b[i] = 8'(8'h51 + i * 17);
    for (int w = 0; w < 2; w++)
      exp_q.push_back({8'(w), b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
    do_start(8'd2);
    send_byte(b[0], 0);
    send_byte(b[1], 0);
    do_start(8'd9);
    n_vec++;
    if (state !== ST_LOAD || busy !== 1'b1) begin
      n_err++;
      $display("FAIL restart_state: got state=%0d busy=%b, required %0d/1", state, busy, ST_LOAD);
    end
    for (int i = 2; i < 8; i++) send_byte(b[i], 0);
    wait_idle(20, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0 || wr_cnt != 2 || done_cnt != 1) begin
      n_err++;
      $display("FAIL restart_end: got idle=%0d left=%0d writes=%0d dones=%0d, required 1/0/2/1",
               ok, exp_q.size(), wr_cnt, done_cnt);
    end
  endtask

  task automatic test_full();
    bit ok;
    logic [7:0] b[4];
    clear_sb();
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'((4 * w + k) ^ ((4 * w + k) >> 3));
      exp_q.push_back({8'(w), b[3], b[2], b[1], b[0]});
    end
    do_start(8'd0);
    for (int i = 0; i < 1024; i++) send_byte(8'(i ^ (i >> 3)), 0);
    wait_idle(20, ok);
    n_vec++;
    if (!ok || exp_q.size() != 0 || wr_cnt != 256) begin
      n_err++;
      $display("FAIL full_count: got idle=%0d left=%0d writes=%0d, required 1/0/256",
               ok, exp_q.size(), wr_cnt);
    end
    repeat (3) step();
    n_vec++;
    if (last_waddr !== 8'd255 || done_cnt != 1 || wr_cnt != 256) begin
      n_err++;
      $display("FAIL full_last: got last_waddr=%0d dones=%0d writes=%0d, required 255/1/256",
               last_waddr, done_cnt, wr_cnt);
    end
  endtask

  task automatic test_reset_in_write();
    clear_sb();
    do_start(8'd2);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    n_vec++;
    if (we !== 1'b1) begin
      n_err++;
      $display("FAIL rstw_pre: got we=%b, required 1", we);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({we, in_ready, busy, cpu_hold, done} !== 5'b0 || waddr !== '0 || wdata !== '0) begin
      n_err++;
      $display("FAIL rstw_async: got ctrl=%b waddr=%h wdata=%h, required 00000/0/0",
               {we, in_ready, busy, cpu_hold, done}, waddr, wdata);
    end
    step();
    step();
    rst = 1'b1;
    n_vec++;
    if (wr_cnt != 0 || done_cnt != 0) begin
      n_err++;
      $display("FAIL rstw_nowrite: got writes=%0d dones=%0d, required 0/0", wr_cnt, done_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    in_data = '0;
    in_valid = 1'b0;
    #12;
    test_reset();
    step();
    rst = 1'b1;
    test_single();
    test_gaps();
    test_abort();
    test_start_ignored();
    test_full();
    test_reset_in_write();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, instruction-memory address width (256 words).
REQ-002 The block SHALL have parameter INST_W, default 32, instruction word width; it is fixed at 4 bytes.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-006 The block SHALL have port len  input  ADDR_W  word count, sampled on accepted start; 0 means 256.
REQ-007 The block SHALL have port abort  input  1  synchronous cancel of a load in progress.
REQ-008 The block SHALL have port in_data  input  8  byte stream, little-endian within each word.
REQ-009 The block SHALL have port in_valid  input  1  in_data is valid.
REQ-010 The block SHALL have port in_ready  output  1  the loader accepts in_data this cycle.
REQ-011 The block SHALL have port we  output  1  instruction-memory write strobe.
REQ-012 The block SHALL have port waddr  output  ADDR_W  write address.
REQ-013 The block SHALL have port wdata  output  INST_W  write data.
REQ-014 The block SHALL have port cpu_hold  output  1  holds program_counter in reset while high.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse on successful completion.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, WRITE and DONE.
REQ-018 IDLE->LOAD SHALL occur on start=1; at that edge len is latched, word_cnt=0 and byte_cnt=0.
REQ-019 in_ready SHALL be 1 only in LOAD; a byte transfers when in_valid and in_ready are both 1.
REQ-020 Byte k (k=0..3) of a word SHALL be written into wdata[8k+7:8k]; byte_cnt increments per transfer.
REQ-021 The transfer of byte 3 SHALL move the FSM to WRITE; WRITE lasts exactly one cycle with we=1, waddr=word_cnt and wdata=assembled word.
REQ-022 From WRITE, the FSM SHALL go to DONE if word_cnt equals the latched len-1 (mod 256); otherwise it SHALL go to LOAD with word_cnt+1 and byte_cnt=0.
REQ-023 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-024 we SHALL be 0 in every state other than WRITE; waddr and wdata SHALL hold their last values outside WRITE.
REQ-025 cpu_hold SHALL equal busy, so the PC restarts at 0 when the load ends.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 abort in LOAD or WRITE SHALL return the FSM to IDLE at the next edge with no write that cycle, no done pulse, and the partial word discarded; abort SHALL take priority over the byte transfer and over we.
REQ-028 In_valid gaps SHALL stall without timeout; the byte count is preserved across gaps.
REQ-029 len=0 SHALL load 256 words, addresses 0..255, with no address wrap and no extra write.

Reset
REQ-030 While rst=0, the FSM SHALL be in IDLE and we, in_ready, busy, cpu_hold, done, waddr, wdata, word_cnt and byte_cnt SHALL all be 0.
REQ-031 Reset asserted mid-load SHALL discard the load immediately, asynchronously, with no write.
REQ-032 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-033 The package cpu_pkg SHALL hold ADDR_W, INST_W and the loader state enum, which program_counter and instruction_memory share.
REQ-034 The design SHALL use one sub-module, word_packer, for the byte shift/assembly and byte_cnt; the FSM, word_cnt and outputs SHALL stay in instruction_loader.

Verification
REQ-035 Test: len=1, bytes 04 00 00 00 back-to-back -> one we with waddr=0 and wdata=32'h00000004; done 1 cycle later; cpu_hold falls with done.
REQ-036 Test: len=4, 16 bytes with in_valid toggling every other cycle -> 4 writes at addresses 0..3 with correct words, and each we is exactly one cycle long.
REQ-037 Test: len=0, 1024 bytes -> 256 writes, last at waddr=255, done exactly once.
REQ-038 Test: abort after 2 bytes of word 1 (len=3) -> no further we, no done, busy=0 next cycle; a new load then writes from address 0.
REQ-039 Test: rst=0 during the WRITE cycle -> we drops without waiting for clk, and all outputs are 0.
REQ-040 Test: start pulsed again mid-load with len=9 -> ignored; the original len governs completion.
